iob_axis_s_axi_m_write_burst: RTL and testbench
===============================================

Name: iob_axis_s_axi_m_write_burst

Overview:
Parametrised AXI-Stream-slave to AXI4-write-master DMA engine. It buffers stream beats in an internal synchronous FIFO and issues INCR bursts to a configured byte address. It adds bus-width-generic addressing, 4 KB boundary splitting, multiple outstanding write responses, sticky error reporting and an optional tlast-terminated mode with strobe padding. It sits between a stream producer (e.g. Ethernet RX path) and the system AXI interconnect.

Parameters:
AXI_ADDR_W, 32, address width
AXI_DATA_W, 32, data width; power of 2, >=8
AXI_LEN_W, 8, AXI awlen width
AXI_ID_W, 1, ID width
WLEN_W, 12, transfer length width in beats
FIFO_ADDR_W, 4, log2 FIFO depth (DEPTH=2**FIFO_ADDR_W)
MAX_OUTST, 2, max bursts awaiting B response (1..7)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  synchronous active-low reset
w_addr_i  in  AXI_ADDR_W  start byte address; low log2(AXI_DATA_W/8) bits ignored
w_length_i  in  WLEN_W  transfer length in beats
w_max_len_i  in  AXI_LEN_W+1  max burst beats
w_tlast_mode_i  in  1  1: end transfer at stream tlast
w_start_transfer_i  in  1  start pulse
w_remaining_data_o  out  WLEN_W  beats not yet issued
w_busy_o  out  1  transfer active
w_done_o  out  1  one-cycle completion pulse
w_error_o  out  1  sticky: any bresp!=OKAY
axis_in_tdata_i  in  AXI_DATA_W  stream data
axis_in_tlast_i  in  1  stream last
axis_in_tvalid_i  in  1  stream valid
axis_in_tready_o  out  1  stream ready
axi_awid_o/awaddr_o/awlen_o/awsize_o/awburst_o/awlock_o(2)/awcache_o(4)/awqos_o(4)/awvalid_o  out  AW channel
axi_awready_i  in  1
axi_wdata_o  out  AXI_DATA_W; axi_wstrb_o  out  AXI_DATA_W/8; axi_wlast_o, axi_wvalid_o  out  1
axi_wready_i  in  1
axi_bid_i  in  AXI_ID_W; axi_bresp_i  in  2; axi_bvalid_i  in  1; axi_bready_o  out  1

Behaviour:
- Single clock clk_i; synchronous active-low reset rst_n_i. On reset: FIFO empty, state IDLE, all valids 0, w_busy/done/error 0, w_remaining 0, outstanding count 0. Reset mid-transfer aborts immediately; the AXI slave is reset in the same domain.
- FIFO: DEPTH x (AXI_DATA_W+1) stores data+tlast; tready=!full; push on tvalid&tready; keeps a count of stored tlast beats. Excess beats persist into the next transfer.
- Constants: awsize=log2(AXI_DATA_W/8), awburst=2'b01, awlock=0, awcache=4'b0010, awqos=0, awid=0. bready=1 always.
- FSM IDLE: busy=0. On start: latch aligned address, remaining=w_length_i, mode; clear error; go CALC. Start while busy is ignored. w_length_i=0: done pulse next cycle, no AXI traffic.
- CALC: len = min(remaining, clamp(w_max_len_i,1,min(2**AXI_LEN_W,DEPTH)), beats to next 4 KB boundary). Launch when outstanding<MAX_OUTST and (FIFO level>=len, or tlast mode with tlast count>0). Then awaddr=addr, awlen=len-1, go ADDR. remaining-=len, addr+=len*(AXI_DATA_W/8).
- ADDR: awvalid held until awready; outstanding++ on handshake; go DATA. W is never driven before its AW handshake.
- DATA: wvalid high, wdata from FIFO head; pop on wvalid&wready; wlast on beat len; wstrb all ones. Tlast mode: after the tlast beat is popped, remaining beats of the burst are padded with wdata=0, wstrb=0; remaining forced to 0. After wlast handshake: remaining>0 -> CALC, else DRAIN.
- DRAIN: wait outstanding==0, then w_done_o pulse, go IDLE.
- B handshake: outstanding--; simultaneous AW and B handshakes leave the count unchanged; bresp!=0 sets w_error_o (held until the next start).
- Tlast mode with no tlast before length exhausts: ends normally at w_length_i beats.

Test Plan:
- DATA_W=32, addr 0x1000, len 20, max_len 8, stream continuous -> bursts awlen 7,7,3 at 0x1000,0x1020,0x1040; done after 3 B; remaining 0.
- addr 0x0FF8, len 8, max_len 16 -> split 4 KB: awlen 1 at 0x0FF8, awlen 5 at 0x1000.
- DATA_W=64, addr 0x100, len 4 -> awsize 3, awaddr 0x100, wstrb 0xFF, 4 beats.
- Tlast mode, len 16, max_len 8, tlast on beat 3 -> one burst awlen 7: 3 data beats then 5 beats wstrb 0; done; w_remaining 0.
- awready delayed, bvalid delayed 10 cycles, MAX_OUTST=2, len 32, max_len 8 -> never more than 2 B outstanding; bresp=2'b10 on 2nd burst -> w_error_o 1 at done, cleared on next start.
- rst_n_i low mid-DATA -> next cycle all valids 0, busy 0, tready 1; subsequent transfer completes correctly.

Source files
------------

// File: rtl/iob_axis_s_axi_m_write_burst.sv
// AXI-Stream slave to AXI4 write-burst master: buffers stream beats in a FIFO and
// issues INCR bursts, split by max burst length and 4 KB boundaries.
module iob_axis_s_axi_m_write_burst #(
    parameter int AXI_ADDR_W  = 32,
    parameter int AXI_DATA_W  = 32,
    parameter int AXI_LEN_W   = 8,
    parameter int AXI_ID_W    = 1,
    parameter int WLEN_W      = 12,
    parameter int FIFO_ADDR_W = 4,
    parameter int MAX_OUTST   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [AXI_ADDR_W-1:0]   w_addr_i,
    input  logic [WLEN_W-1:0]       w_length_i,
    input  logic [AXI_LEN_W:0]      w_max_len_i,
    input  logic                    w_tlast_mode_i,
    input  logic                    w_start_transfer_i,
    output logic [WLEN_W-1:0]       w_remaining_data_o,
    output logic                    w_busy_o,
    output logic                    w_done_o,
    output logic                    w_error_o,
    input  logic [AXI_DATA_W-1:0]   axis_in_tdata_i,
    input  logic                    axis_in_tlast_i,
    input  logic                    axis_in_tvalid_i,
    output logic                    axis_in_tready_o,
    output logic [AXI_ID_W-1:0]     axi_awid_o,
    output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic [1:0]              axi_awlock_o,
    output logic [3:0]              axi_awcache_o,
    output logic [3:0]              axi_awqos_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [AXI_DATA_W-1:0]   axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [AXI_ID_W-1:0]     axi_bid_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o
);
    localparam int STRB_W  = AXI_DATA_W / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int DEPTH   = 2 ** FIFO_ADDR_W;
    localparam int LEN_LIM = (2 ** AXI_LEN_W < DEPTH) ? 2 ** AXI_LEN_W : DEPTH;
    localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = AXI_ADDR_W'(STRB_W - 1);

    typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DRAIN} state_t;
    state_t state;

    logic [AXI_DATA_W:0]    mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [FIFO_ADDR_W:0]   level, tlast_cnt;
    logic [AXI_DATA_W:0]    head;
    logic                   push, pop, full, empty, head_last;

    logic [AXI_ADDR_W-1:0]  addr;
    logic [WLEN_W-1:0]      remaining;
    logic [AXI_LEN_W:0]     max_len;
    logic [AXI_LEN_W-1:0]   beat;
    logic [2:0]             outst;
    logic                   tlast_mode, pad, aw_fire, w_fire, b_fire, launch, last_pop;
    logic [31:0]            rem32, max32, bnd32, len32;
    logic                   unused_bid;

    assign full             = level == (FIFO_ADDR_W + 1)'(DEPTH);
    assign empty            = level == '0;
    assign axis_in_tready_o = !full;
    assign push             = axis_in_tvalid_i && !full;
    assign head             = mem[rd_ptr];
    assign head_last        = head[AXI_DATA_W];
    assign pop              = w_fire && !pad;
    assign unused_bid       = ^axi_bid_i;

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {axis_in_tlast_i, axis_in_tdata_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            tlast_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + (FIFO_ADDR_W + 1)'(1);
                2'b01:   level <= level - (FIFO_ADDR_W + 1)'(1);
                default: ;
            endcase
            case ({push && axis_in_tlast_i, pop && head_last})
                2'b10:   tlast_cnt <= tlast_cnt + (FIFO_ADDR_W + 1)'(1);
                2'b01:   tlast_cnt <= tlast_cnt - (FIFO_ADDR_W + 1)'(1);
                default: ;
            endcase
        end
    end

    // Burst length: remaining beats, clamped max length, beats left in the 4 KB page.
    always_comb begin
        rem32 = 32'(remaining);
        max32 = 32'(max_len);
        if (max32 == 32'd0) max32 = 32'd1;
        else if (max32 > 32'(LEN_LIM)) max32 = 32'(LEN_LIM);
        bnd32 = (32'd4096 - 32'(addr[11:0])) >> BYTE_SH;
        len32 = rem32;
        if (max32 < len32) len32 = max32;
        if (bnd32 < len32) len32 = bnd32;
    end

    assign launch   = (outst < 3'(MAX_OUTST)) &&
                      ((32'(level) >= len32) || (tlast_mode && tlast_cnt != '0));
    assign aw_fire  = axi_awvalid_o && axi_awready_i;
    assign w_fire   = axi_wvalid_o && axi_wready_i;
    assign b_fire   = axi_bvalid_i && axi_bready_o;
    assign last_pop = pop && tlast_mode && head_last;

    assign axi_wvalid_o = (state == DATA) && (pad || !empty);
    assign axi_wdata_o  = pad ? '0 : head[AXI_DATA_W-1:0];
    assign axi_wstrb_o  = pad ? '0 : '1;
    assign axi_wlast_o  = (state == DATA) && (beat == axi_awlen_o);

    assign axi_awid_o         = '0;
    assign axi_awsize_o       = 3'(BYTE_SH);
    assign axi_awburst_o      = 2'b01;
    assign axi_awlock_o       = 2'b00;
    assign axi_awcache_o      = 4'b0010;
    assign axi_awqos_o        = 4'b0000;
    assign axi_bready_o       = 1'b1;
    assign w_busy_o           = state != IDLE;
    assign w_remaining_data_o = remaining;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            addr          <= '0;
            remaining     <= '0;
            max_len       <= '0;
            tlast_mode    <= 1'b0;
            pad           <= 1'b0;
            beat          <= '0;
            outst         <= '0;
            axi_awaddr_o  <= '0;
            axi_awlen_o   <= '0;
            axi_awvalid_o <= 1'b0;
            w_done_o      <= 1'b0;
            w_error_o     <= 1'b0;
        end else begin
            w_done_o <= 1'b0;
            if (b_fire && axi_bresp_i != 2'b00) w_error_o <= 1'b1;
            case ({aw_fire, b_fire})
                2'b10:   outst <= outst + 3'd1;
                2'b01:   outst <= outst - 3'd1;
                default: ;
            endcase
            case (state)
                IDLE: if (w_start_transfer_i) begin
                    w_error_o  <= 1'b0;
                    addr       <= w_addr_i & ~ALIGN_MASK;
                    remaining  <= w_length_i;
                    max_len    <= w_max_len_i;
                    tlast_mode <= w_tlast_mode_i;
                    if (w_length_i == '0) w_done_o <= 1'b1;
                    else state <= CALC;
                end
                CALC: if (launch) begin
                    axi_awaddr_o  <= addr;
                    axi_awlen_o   <= AXI_LEN_W'(len32 - 32'd1);
                    axi_awvalid_o <= 1'b1;
                    beat          <= '0;
                    remaining     <= remaining - WLEN_W'(len32);
                    addr          <= addr + AXI_ADDR_W'(len32 << BYTE_SH);
                    state         <= ADDR;
                end
                ADDR: if (axi_awready_i) begin
                    axi_awvalid_o <= 1'b0;
                    state         <= DATA;
                end
                DATA: if (w_fire) begin
                    beat <= beat + AXI_LEN_W'(1);
                    // Once the packet ends, the rest of this burst is strobe-less padding.
                    if (last_pop) begin
                        pad       <= 1'b1;
                        remaining <= '0;
                    end
                    if (axi_wlast_o) begin
                        pad   <= 1'b0;
                        state <= (remaining != '0 && !last_pop) ? CALC : DRAIN;
                    end
                end
                DRAIN: if (outst == '0) begin
                    w_done_o <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_axis_s_axi_m_write_burst.sv
// Bench for the stream-to-AXI write burst engine: table of directed transfers plus
// random ones, each checked against a burst/beat list built from the addressing rules.
module tb_iob_axis_s_axi_m_write_burst;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] w_addr;
    logic [11:0] w_length, remaining;
    logic [8:0]  w_max_len;
    logic        w_tlast_mode, start, busy, done, error;
    logic [31:0] tdata;
    logic        tlast, tvalid, tready;
    logic [0:0]  awid, bid;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, awlock, bresp;
    logic [3:0]  awcache, awqos, wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    iob_axis_s_axi_m_write_burst #(
        .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8), .AXI_ID_W(1),
        .WLEN_W(12), .FIFO_ADDR_W(4), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .w_addr_i(w_addr), .w_length_i(w_length), .w_max_len_i(w_max_len),
        .w_tlast_mode_i(w_tlast_mode), .w_start_transfer_i(start),
        .w_remaining_data_o(remaining), .w_busy_o(busy), .w_done_o(done), .w_error_o(error),
        .axis_in_tdata_i(tdata), .axis_in_tlast_i(tlast), .axis_in_tvalid_i(tvalid),
        .axis_in_tready_o(tready),
        .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
        .axi_awburst_o(awburst), .axi_awlock_o(awlock), .axi_awcache_o(awcache),
        .axi_awqos_o(awqos), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast), .axi_wvalid_o(wvalid),
        .axi_wready_i(wready),
        .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          max_len;
        bit          tmode;
        int          tpos;
        int          bdelay;
        int          err_idx;
        bit          restart;
        int          exp_bursts;
        bit          exp_err;
    } vec_t;
    typedef struct { logic [31:0] addr; int len; } burst_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; bit last; } beat_t;
    typedef struct { logic [31:0] data; bit last; } sbeat_t;

    sbeat_t      sq[$];
    burst_t      aw_got[$];
    beat_t       w_got[$];
    int          b_at[$];
    logic [1:0]  b_rsp[$];
    int          cyc = 0;
    int          outst, max_outst, wl_cnt, early_w, bdelay, err_idx;
    int          n_vec = 0, n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Stream producer with random gaps.
    initial begin
        tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin tvalid = 1'b0; continue; end
            if (sq.size() > 0 && $urandom_range(0, 3) != 0) begin
                tvalid = 1'b1; tdata = sq[0].data; tlast = sq[0].last;
            end else tvalid = 1'b0;
            if (tvalid && tready) void'(sq.pop_front());
        end
    end

    // AXI slave: random AW/W ready, B returned bdelay cycles after each wlast.
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
        outst = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                b_at.delete(); b_rsp.delete(); outst = 0;
                continue;
            end
            awready = ($urandom_range(0, 2) != 0);
            wready  = ($urandom_range(0, 3) != 0);
            if (wvalid && aw_got.size() <= wl_cnt) early_w++;
            if (awvalid && awready) begin
                aw_got.push_back('{awaddr, int'(awlen) + 1});
                outst++;
                if (outst > max_outst) max_outst = outst;
            end
            if (wvalid && wready) begin
                w_got.push_back('{wdata, wstrb, wlast});
                if (wlast) begin
                    b_at.push_back(cyc + bdelay);
                    b_rsp.push_back(wl_cnt == err_idx ? 2'b10 : 2'b00);
                    wl_cnt++;
                end
            end
            if (b_at.size() > 0 && cyc >= b_at[0]) begin
                bvalid = 1'b1; bresp = b_rsp[0];
            end else begin
                bvalid = 1'b0; bresp = 2'b00;
            end
            if (bvalid && bready) begin
                void'(b_at.pop_front()); void'(b_rsp.pop_front()); outst--;
            end
        end
    end

    task automatic run(input vec_t v, input string tag);
        burst_t      eb[$];
        beat_t       ebeat[$];
        logic [31:0] sdata[$];
        logic [31:0] a;
        int          r, m, l, g, n_data, lim;
        bit          tl, seen, exp_err;
        tl     = v.tmode && v.tpos >= 1 && v.tpos <= v.len;
        n_data = tl ? v.tpos : v.len;
        for (int i = 0; i < n_data; i++) sdata.push_back($urandom);
        // Expected bursts and beats from the addressing rules.
        a = v.addr & ~32'd3;
        r = v.len;
        m = (v.max_len == 0) ? 1 : (v.max_len > 16 ? 16 : v.max_len);
        g = 0;
        while (r > 0) begin
            lim = (4096 - int'(a % 4096)) / 4;
            l = r;
            if (m < l) l = m;
            if (lim < l) l = lim;
            eb.push_back('{a, l});
            for (int k = 0; k < l; k++) begin
                if (g < n_data) ebeat.push_back('{sdata[g], 4'hF, k == l - 1});
                else ebeat.push_back('{32'h0, 4'h0, k == l - 1});
                g++;
            end
            a += 32'(4 * l);
            r -= l;
            if (tl && g >= n_data) break;
        end
        exp_err = v.err_idx >= 0 && v.err_idx < eb.size();

        aw_got.delete(); w_got.delete();
        wl_cnt = 0; max_outst = 0; early_w = 0;
        bdelay = v.bdelay; err_idx = v.err_idx;
        for (int i = 0; i < n_data; i++) sq.push_back('{sdata[i], i == v.tpos - 1});

        @(negedge clk);
        w_addr = v.addr; w_length = 12'(v.len); w_max_len = 9'(v.max_len);
        w_tlast_mode = v.tmode; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.len == 0) begin
            check({tag, " zero-len done"}, 64'(done), 64'd1);
            @(negedge clk);
            @(negedge clk);
            check({tag, " zero-len done pulse"}, 64'(done), 64'd0);
            check({tag, " zero-len no AW"}, 64'(aw_got.size()), 64'd0);
            check({tag, " zero-len error"}, 64'(error), 64'd0);
            return;
        end
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " error cleared"}, 64'(error), 64'd0);
        if (v.restart) begin
            repeat (3) @(negedge clk);
            w_addr = 32'h8000; w_length = 12'd5; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 1500 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " remaining"}, 64'(remaining), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
        check({tag, " error"}, 64'(error), 64'(exp_err));
        if (v.exp_bursts >= 0) check({tag, " table bursts"}, 64'(aw_got.size()), 64'(v.exp_bursts));
        check({tag, " bursts"}, 64'(aw_got.size()), 64'(eb.size()));
        for (int i = 0; i < eb.size() && i < aw_got.size(); i++) begin
            check($sformatf("%s awaddr[%0d]", tag, i), 64'(aw_got[i].addr), 64'(eb[i].addr));
            check($sformatf("%s awlen[%0d]", tag, i), 64'(aw_got[i].len), 64'(eb[i].len));
        end
        check({tag, " beats"}, 64'(w_got.size()), 64'(ebeat.size()));
        for (int i = 0; i < ebeat.size() && i < w_got.size(); i++)
            check($sformatf("%s beat[%0d]", tag, i),
                  {27'd0, w_got[i].last, w_got[i].strb, w_got[i].data},
                  {27'd0, ebeat[i].last, ebeat[i].strb, ebeat[i].data});
        check({tag, " no W before AW"}, 64'(early_w), 64'd0);
        check({tag, " outstanding<=MAX"}, 64'(max_outst <= MO), 64'd1);
        check({tag, " stream consumed"}, 64'(sq.size()), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[10];
        vec_t rv;
        bit   found;
        vt[0] = '{32'h1000, 20,   8, 0,  0,  2, -1, 0, 3, 0};
        vt[1] = '{32'h0FF8,  8,  16, 0,  0,  1, -1, 0, 2, 0};
        vt[2] = '{32'h1000, 16,   8, 1,  3,  2, -1, 0, 1, 0};
        vt[3] = '{32'h2000, 32,   8, 0,  0, 10,  1, 0, 4, 1};
        vt[4] = '{32'h3000,  0,   8, 0,  0,  0, -1, 0, 0, 0};
        vt[5] = '{32'h2003,  5,   0, 0,  0,  0, -1, 0, 5, 0};
        vt[6] = '{32'h3000, 40, 100, 0,  0,  3, -1, 0, 3, 0};
        vt[7] = '{32'h4000, 16,   8, 1, 20,  2, -1, 0, 2, 0};
        vt[8] = '{32'h5000, 24,   8, 1,  8,  1, -1, 0, 1, 0};
        vt[9] = '{32'h6000, 12,   4, 0,  0,  2, -1, 1, 3, 0};

        rst_n = 1'b0; start = 1'b0; w_addr = '0; w_length = '0; w_max_len = '0;
        w_tlast_mode = 1'b0; bdelay = 0; err_idx = -1;
        wl_cnt = 0; max_outst = 0; early_w = 0;
        repeat (3) @(negedge clk);
        check("reset tready", 64'(tready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset error", 64'(error), 64'd0);
        check("reset remaining", 64'(remaining), 64'd0);
        check("reset awvalid", 64'(awvalid), 64'd0);
        check("reset wvalid", 64'(wvalid), 64'd0);
        check("bready", 64'(bready), 64'd1);
        check("awsize/burst/cache", {56'd0, awsize, awburst, awcache[2:0]}, {56'd0, 3'd2, 2'b01, 3'b010});
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run(vt[i], $sformatf("vec%0d", i));

        // Reset in the middle of a data phase aborts everything at once.
        sq.delete();
        for (int i = 0; i < 20; i++) sq.push_back('{$urandom, 1'b0});
        @(negedge clk);
        w_addr = 32'h7000; w_length = 12'd20; w_max_len = 9'd8; w_tlast_mode = 1'b0;
        bdelay = 2; err_idx = -1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (wvalid) found = 1'b1;
        end
        check("rst-mid reached DATA", 64'(found), 64'd1);
        rst_n = 1'b0;
        sq.delete();
        @(negedge clk);
        @(negedge clk);
        check("rst-mid awvalid", 64'(awvalid), 64'd0);
        check("rst-mid wvalid", 64'(wvalid), 64'd0);
        check("rst-mid busy", 64'(busy), 64'd0);
        check("rst-mid tready", 64'(tready), 64'd1);
        check("rst-mid remaining", 64'(remaining), 64'd0);
        rst_n = 1'b1;
        sq.delete();
        run(vt[0], "after-reset");

        for (int i = 0; i < 14; i++) begin
            rv.addr       = 32'h10000 + 32'($urandom_range(0, 4095));
            rv.len        = int'($urandom_range(1, 40));
            rv.max_len    = int'($urandom_range(0, 20));
            rv.tmode      = 1'($urandom_range(0, 1));
            rv.tpos       = int'($urandom_range(1, 45));
            rv.bdelay     = int'($urandom_range(0, 12));
            rv.err_idx    = int'($urandom_range(0, 6)) - 1;
            rv.restart    = 1'b0;
            rv.exp_bursts = -1;
            rv.exp_err    = 1'b0;
            run(rv, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
